// File: rtl/store_write_buffer_pkg.sv
// Shared types and constants for the store write buffer (package sb_pkg).
// Optional load forwarding is enabled by defining STORE_BUFFER_FWD_EN.
package sb_pkg;

  localparam int SB_DEPTH_DEF = 4;
  localparam int SB_AW        = 32;
  localparam int SB_DW        = 32;

  // One buffered store at the default address/data widths.
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  // Occupancy classes. They are derived from count and are never stored.
  typedef enum logic [1:0] {
    SB_EMPTY,
    SB_PARTIAL,
    SB_FULL
  } sb_state_t;

  // Pointer width for a power-of-two depth.
  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/store_buffer_fwd.sv
// Youngest-match search over the valid store buffer entries.
// This block is only instantiated when STORE_BUFFER_FWD_EN is defined.
module store_buffer_fwd
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic [AW-1:0]            ent_addr [DEPTH],
  input  logic [DW-1:0]            ent_data [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  input  logic [$clog2(DEPTH):0]   cnt,
  input  logic [AW-1:0]            rd_addr,
  output logic                     hit,
  output logic [DW-1:0]            data
);

  localparam int PW = sb_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk the entries from oldest to youngest so that a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < cnt) && (ent_addr[idx] == rd_addr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the core data port and a slower data memory.
// Define STORE_BUFFER_FWD_EN to enable load forwarding (fwd_hit/fwd_data);
// otherwise rd_addr is ignored and both forwarding outputs are tied to 0.
module store_write_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWrite,
  input  logic [AW-1:0]          DataAdr,
  input  logic [DW-1:0]          WriteData,
  output logic                   Stall,
  output logic                   mem_valid,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   overflow,
  input  logic [AW-1:0]          rd_addr,
  output logic                   fwd_hit,
  output logic [DW-1:0]          fwd_data
);

  localparam int PW = sb_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] nxt_rd;
  logic [CW-1:0] cnt;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  sb_state_t     state;
  logic          enq;
  logic          deq;

  // Occupancy class and handshakes, decoded from registered count only.
  always_comb begin
    state = SB_PARTIAL;
    if (cnt == '0)
      state = SB_EMPTY;
    else if (cnt == CW'(DEPTH))
      state = SB_FULL;
    empty     = (state == SB_EMPTY);
    Stall     = (state == SB_FULL);
    mem_valid = !empty;
    enq       = MemWrite && !Stall;
    deq       = mem_valid && mem_ready;
    nxt_rd    = rd_ptr + PW'(1);
  end

  // Entry storage; only slots inside the count window are ever read.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr] <= DataAdr;
      ent_data[wr_ptr] <= WriteData;
    end
  end

  // Pointers, occupancy, sticky overflow and the registered head entry.
  // The head register is loaded with whichever entry becomes oldest after this
  // edge, and keeps its value when the buffer drains empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      head_addr <= '0;
      head_data <= '0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + PW'(1);
      if (deq)
        rd_ptr <= nxt_rd;
      if (enq && !deq)
        cnt <= cnt + CW'(1);
      else if (deq && !enq)
        cnt <= cnt - CW'(1);
      if (MemWrite && Stall)
        overflow <= 1'b1;
      if (deq) begin
        if (cnt > CW'(1)) begin
          head_addr <= ent_addr[nxt_rd];
          head_data <= ent_data[nxt_rd];
        end else if (enq) begin
          head_addr <= DataAdr;
          head_data <= WriteData;
        end
      end else if (enq && empty) begin
        head_addr <= DataAdr;
        head_data <= WriteData;
      end
    end
  end

  assign count     = cnt;
  assign mem_addr  = head_addr;
  assign mem_wdata = head_data;

`ifdef STORE_BUFFER_FWD_EN
  store_buffer_fwd #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .rd_ptr   (rd_ptr),
    .cnt      (cnt),
    .rd_addr  (rd_addr),
    .hit      (fwd_hit),
    .data     (fwd_data)
  );
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign fwd_hit        = 1'b0;
  assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer (DEPTH=4, AW=DW=32).
module tb_store_write_buffer;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        Stall;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [2:0]  count;
  logic        empty;
  logic        overflow;
  logic [31:0] rd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int vectors;
  int miscompares;

  store_write_buffer #(
    .DEPTH (4),
    .AW    (32),
    .DW    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .Stall     (Stall),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .count     (count),
    .empty     (empty),
    .overflow  (overflow),
    .rd_addr   (rd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic exp_hit;
    logic [31:0] exp_fd;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    MemWrite    = 1'b0;
    DataAdr     = '0;
    WriteData   = '0;
    mem_ready   = 1'b0;
    rd_addr     = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_stall", 64'(Stall), 64'd0);
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("rst_fwd_data", 64'(fwd_data), 64'd0);

    // Asynchronous reset mid-cycle with two entries pending
    store(32'h1, 32'hB1);
    store(32'h2, 32'hB2);
    chk("pend_count", 64'(count), 64'd2);
    chk("pend_valid", 64'(mem_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(mem_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_stall", 64'(Stall), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    tick();
    reset = 1'b0;

    // Single store with memory ready
    mem_ready = 1'b1;
    store(32'h61, 32'h25);
    chk("single_valid", 64'(mem_valid), 64'd1);
    chk("single_addr", 64'(mem_addr), 64'h61);
    chk("single_wdata", 64'(mem_wdata), 64'h25);
    tick();
    chk("single_empty", 64'(empty), 64'd1);
    chk("single_valid0", 64'(mem_valid), 64'd0);
    chk("single_hold_addr", 64'(mem_addr), 64'h61);

    // Fill to full with memory stalled
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_stall_lo", 64'(Stall), 64'd0);
      store(32'h10 + 32'(i), 32'hA0 + 32'(i));
    end
    chk("full_stall", 64'(Stall), 64'd1);
    chk("full_count", 64'(count), 64'd4);
    chk("full_head", 64'(mem_addr), 64'h10);
    // Fifth store held by the core while stalled
    MemWrite  = 1'b1;
    DataAdr   = 32'h14;
    WriteData = 32'hA4;
    tick();
    chk("held_count", 64'(count), 64'd4);
    chk("held_head", 64'(mem_addr), 64'h10);
    // Enqueue blocked on the edge that frees a slot
    mem_ready = 1'b1;
    tick();
    chk("free_count", 64'(count), 64'd3);
    chk("free_stall", 64'(Stall), 64'd0);
    chk("drain_addr1", 64'(mem_addr), 64'h11);
    chk("drain_data1", 64'(mem_wdata), 64'hA1);
    tick();
    MemWrite = 1'b0;
    chk("cap_count", 64'(count), 64'd3);
    chk("drain_addr2", 64'(mem_addr), 64'h12);
    tick();
    chk("drain_addr3", 64'(mem_addr), 64'h13);
    chk("drain_data3", 64'(mem_wdata), 64'hA3);
    tick();
    chk("drain_addr4", 64'(mem_addr), 64'h14);
    chk("drain_data4", 64'(mem_wdata), 64'hA4);
    chk("drain_count4", 64'(count), 64'd1);
    tick();
    chk("drain_empty", 64'(empty), 64'd1);

    // Store while full sets sticky overflow
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h50 + 32'(i), 32'hC0 + 32'(i));
    store(32'h20, 32'hEE);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd4);
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        chk("ovf_drain_addr", 64'(mem_addr), 64'h50 + 64'(i));
        chk("ovf_drain_data", 64'(mem_wdata), 64'hC0 + 64'(i));
      end
      tick();
      chk("ovf_sticky", 64'(overflow), 64'd1);
    end
    chk("ovf_dropped_empty", 64'(empty), 64'd1);
    chk("ovf_last_addr", 64'(mem_addr), 64'h53);
    do_reset();
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Simultaneous enqueue and dequeue at count 2
    mem_ready = 1'b0;
    store(32'h31, 32'h61);
    store(32'h32, 32'h62);
    chk("sim_count_pre", 64'(count), 64'd2);
    mem_ready = 1'b1;
    store(32'h30, 32'h55);
    chk("sim_count", 64'(count), 64'd2);
    chk("sim_addr1", 64'(mem_addr), 64'h32);
    chk("sim_data1", 64'(mem_wdata), 64'h62);
    tick();
    chk("sim_addr2", 64'(mem_addr), 64'h30);
    chk("sim_data2", 64'(mem_wdata), 64'h55);
    tick();
    chk("sim_empty", 64'(empty), 64'd1);

    // Forwarding lookup
    do_reset();
    mem_ready = 1'b0;
    store(32'h40, 32'h11);
    store(32'h40, 32'h22);
`ifdef STORE_BUFFER_FWD_EN
    exp_hit = 1'b1;
    exp_fd  = 32'h22;
`else
    exp_hit = 1'b0;
    exp_fd  = 32'h0;
`endif
    rd_addr = 32'h40;
    #1;
    chk("fwd_hit_40", 64'(fwd_hit), 64'(exp_hit));
    chk("fwd_data_40", 64'(fwd_data), 64'(exp_fd));
    rd_addr = 32'h44;
    #1;
    chk("fwd_hit_44", 64'(fwd_hit), 64'd0);
    chk("fwd_data_44", 64'(fwd_data), 64'd0);
    // A store being captured this cycle is not yet visible
    MemWrite  = 1'b1;
    DataAdr   = 32'h44;
    WriteData = 32'h33;
    #1;
    chk("fwd_inflight", 64'(fwd_hit), 64'd0);
    tick();
    MemWrite = 1'b0;
    chk("fwd_count", 64'(count), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish before 20000");
    $fatal(1);
  end

endmodule
